// File: rtl/rf_stack_banked.sv
// rf_stack_banked: banked register file with one private bank per interrupt level
// and a global bank for the registers flagged in SharedMask (x0 reads as zero).
// Reads are combinational on NumReadPorts ports with a same-cycle write bypass.
// Optional feature macro RF_SCRUB_EN: a clear-on-entry scrub engine that zeroes the
// private bank of a newly entered level, stalling the core via busy while it runs.
module rf_stack_banked #(
   parameter int DataWidth = 32,
   parameter int NumRegs = 32,
   parameter int NumLevels = 8,
   parameter int NumReadPorts = 2,
   parameter logic [NumRegs-1:0] SharedMask = 32'h0000_0004,
   localparam int IndexWidth = $clog2(NumRegs),
   localparam int IndexLevels = $clog2(NumLevels)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [IndexLevels-1:0]              level,
   input  logic                                writeEn,
   input  logic [IndexWidth-1:0]               writeAddr,
   input  logic [DataWidth-1:0]                writeData,
   input  logic [NumReadPorts*IndexWidth-1:0]  readAddr,
   output logic [NumReadPorts*DataWidth-1:0]   readData,
   input  logic                                levelEnter,
   output logic                                busy
);

   logic [DataWidth-1:0] bankMem [NumLevels][NumRegs];
   logic [DataWidth-1:0] sharedMem [NumRegs];

   logic busyInt;     // scrub engine owns the banks this cycle
   logic scrubHit;    // current level is the one being scrubbed
   logic writeOk;

`ifdef RF_SCRUB_EN
   typedef enum logic {Idle, Scrub} scrubState_t;

   scrubState_t            stateReg, stateNext;
   logic [IndexWidth-1:0]  scrubIdxReg, scrubIdxNext;
   logic [IndexLevels-1:0] scrubLevelReg, scrubLevelNext;

   // Scrub state register
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg      <= Idle;
         scrubIdxReg   <= '0;
         scrubLevelReg <= '0;
      end else begin
         stateReg      <= stateNext;
         scrubIdxReg   <= scrubIdxNext;
         scrubLevelReg <= scrubLevelNext;
      end
   end

   // Scrub next-state: latch the entered level, then walk x1..x(NumRegs-1)
   always_comb begin
      stateNext      = stateReg;
      scrubIdxNext   = scrubIdxReg;
      scrubLevelNext = scrubLevelReg;
      case (stateReg)
         Idle: begin
            if (levelEnter) begin
               stateNext      = Scrub;
               scrubIdxNext   = IndexWidth'(1);
               scrubLevelNext = level;
            end
         end
         Scrub: begin
            scrubIdxNext = scrubIdxReg + 1'b1;
            if (scrubIdxReg == IndexWidth'(NumRegs - 1)) begin
               stateNext = Idle;
            end
         end
         default: stateNext = Idle;
      endcase
   end

   assign busyInt  = (stateReg == Scrub);
   assign scrubHit = busyInt && (level == scrubLevelReg);
`else
   logic unusedLevelEnter;
   assign unusedLevelEnter = levelEnter;
   assign busyInt  = 1'b0;
   assign scrubHit = 1'b0;
`endif

   assign busy    = busyInt;
   assign writeOk = writeEn && (writeAddr != '0) && !busyInt;

   // Storage update: core writes, scrub clears, reset wipes everything
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int l = 0; l < NumLevels; l++) begin
            for (int r = 0; r < NumRegs; r++) begin
               bankMem[l][r] <= '0;
            end
         end
         for (int r = 0; r < NumRegs; r++) begin
            sharedMem[r] <= '0;
         end
      end else begin
         if (writeOk) begin
            if (SharedMask[writeAddr]) begin
               sharedMem[writeAddr] <= writeData;
            end else begin
               bankMem[level][writeAddr] <= writeData;
            end
         end
`ifdef RF_SCRUB_EN
         // Core writes are blocked while busy, so this never collides with them
         if (busyInt && !SharedMask[scrubIdxReg]) begin
            bankMem[scrubLevelReg][scrubIdxReg] <= '0;
         end
`endif
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NumReadPorts; gi++) begin : genRead
         logic [IndexWidth-1:0] portAddr;
         logic [DataWidth-1:0]  portData;

         assign portAddr = readAddr[gi*IndexWidth +: IndexWidth];

         // Read mux: x0, write bypass, shared bank, scrub masking, private bank
         always_comb begin
            portData = bankMem[level][portAddr];
            if (portAddr == '0) begin
               portData = '0;
            end else if (writeEn && !busyInt && (portAddr == writeAddr)) begin
               portData = writeData;
            end else if (SharedMask[portAddr]) begin
               portData = sharedMem[portAddr];
            end else if (scrubHit) begin
               portData = '0;
            end
         end

         assign readData[gi*DataWidth +: DataWidth] = portData;
      end
   endgenerate

endmodule

// File: tb/tb_rf_stack_banked.sv
// Testbench for rf_stack_banked: directed vector table, scrub/config sequences,
// a 4-port/4-level instance, and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_rf_stack_banked;
   localparam int DW = 32;
   localparam int NR = 32;
   localparam int NL = 8;
   localparam logic [31:0] SHARED = 32'h0000_0004;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  aLevel;
   logic        aWe;
   logic [4:0]  aWa;
   logic [31:0] aWd;
   logic [9:0]  aRa;
   logic [63:0] aRd;
   logic        aLe;
   logic        aBusy;

   logic [1:0]   bLevel;
   logic         bWe;
   logic [4:0]   bWa;
   logic [31:0]  bWd;
   logic [19:0]  bRa;
   logic [127:0] bRd;
   logic         bLe;
   logic         bBusy;

   rf_stack_banked dutA (
      .clk(clk), .reset(reset), .level(aLevel), .writeEn(aWe), .writeAddr(aWa),
      .writeData(aWd), .readAddr(aRa), .readData(aRd), .levelEnter(aLe), .busy(aBusy)
   );

   rf_stack_banked #(.NumReadPorts(4), .NumLevels(4)) dutB (
      .clk(clk), .reset(reset), .level(bLevel), .writeEn(bWe), .writeAddr(bWa),
      .writeData(bWd), .readAddr(bRa), .readData(bRd), .levelEnter(bLe), .busy(bBusy)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rdA(input int p);
      return aRd[p*32 +: 32];
   endfunction

   function automatic logic [31:0] rdB(input int p);
      return bRd[p*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   // Architectural view: a scrub acceptance zeroes the entered level's private bank
   // at once (the core cannot observe it in between), and busy lasts NR-1 cycles.
   logic [31:0] mBank [NL][NR];
   logic [31:0] mShared [NR];
   int busyLeft = 0;

   function automatic logic [31:0] modelRead(input int lvl, input int a, input logic we,
                                             input int wa, input logic [31:0] wd);
      if (a == 0) return 32'h0;
      if (we && busyLeft == 0 && a == wa) return wd;
      if (SHARED[a]) return mShared[a];
      return mBank[lvl][a];
   endfunction

   task automatic modelEdge(input logic rst, input int lvl, input logic we, input int wa,
                            input logic [31:0] wd, input logic le);
      if (rst) begin
         for (int l = 0; l < NL; l++)
            for (int r = 0; r < NR; r++) mBank[l][r] = 32'h0;
         for (int r = 0; r < NR; r++) mShared[r] = 32'h0;
         busyLeft = 0;
      end else begin
         if (we && wa != 0 && busyLeft == 0) begin
            if (SHARED[wa]) mShared[wa] = wd;
            else mBank[lvl][wa] = wd;
         end
`ifdef RF_SCRUB_EN
         if (busyLeft > 0) busyLeft--;
         else if (le) begin
            busyLeft = NR - 1;
            for (int r = 1; r < NR; r++)
               if (!SHARED[r]) mBank[lvl][r] = 32'h0;
         end
`else
         if (le) busyLeft = 0;
`endif
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [2:0]  lvl;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int cnt;
      vecs[0] = '{3'd0, 1'b1, 5'd1,  32'h1234_5678, 5'd0,  5'd1,  32'h0,         32'h1234_5678};
      vecs[1] = '{3'd0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd1,  32'h0,         32'h1234_5678};
      vecs[2] = '{3'd0, 1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd1,  32'hDEAD_BEEF, 32'h1234_5678};
      vecs[3] = '{3'd0, 1'b0, 5'd0,  32'h0,         5'd31, 5'd0,  32'hDEAD_BEEF, 32'h0};
      vecs[4] = '{3'd1, 1'b1, 5'd5,  32'h0000_000A, 5'd5,  5'd31, 32'h0000_000A, 32'h0};
      vecs[5] = '{3'd0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'h0,         32'hDEAD_BEEF};
      vecs[6] = '{3'd3, 1'b1, 5'd2,  32'h0000_0077, 5'd2,  5'd5,  32'h0000_0077, 32'h0};
      vecs[7] = '{3'd0, 1'b0, 5'd0,  32'h0,         5'd2,  5'd1,  32'h0000_0077, 32'h1234_5678};
      vecs[8] = '{3'd1, 1'b0, 5'd0,  32'h0,         5'd5,  5'd2,  32'h0000_000A, 32'h0000_0077};
      vecs[9] = '{3'd1, 1'b1, 5'd5,  32'h0000_000B, 5'd5,  5'd5,  32'h0000_000B, 32'h0000_000B};

      reset = 1'b1; aLevel = '0; aWe = 1'b0; aWa = '0; aWd = '0; aRa = '0; aLe = 1'b0;
      bLevel = '0; bWe = 1'b0; bWa = '0; bWd = '0; bRa = '0; bLe = 1'b0;
      tick();
      reset = 1'b0;

      // Reset state: every register at a few levels reads 0, not busy
      foreach (vecs[k]) begin end
      for (int l = 0; l < NL; l += 3) begin
         for (int r = 0; r < NR; r += 2) begin
            aLevel = 3'(l);
            aRa = {5'(r + 1), 5'(r)};
            @(negedge clk);
            chk($sformatf("reset_l%0d_x%0d", l, r), rdA(0), 32'h0);
            chk($sformatf("reset_l%0d_x%0d", l, r + 1), rdA(1), 32'h0);
            tick();
         end
      end
      chk("reset_busy", 32'(aBusy), 32'h0);

      // Table-driven vectors (sequential, starting from reset state)
      for (int i = 0; i < 10; i++) begin
         aLevel = vecs[i].lvl; aWe = vecs[i].we; aWa = vecs[i].wa; aWd = vecs[i].wd;
         aRa = {vecs[i].ra1, vecs[i].ra0}; aLe = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_p0", i), rdA(0), vecs[i].e0);
         chk($sformatf("vec%0d_p1", i), rdA(1), vecs[i].e1);
         chk($sformatf("vec%0d_busy", i), 32'(aBusy), 32'h0);
         tick();
      end
      aWe = 1'b0;

`ifdef RF_SCRUB_EN
      // Scrub of level 2: private x7 cleared, shared x2 kept, busy for 31 cycles
      reset = 1'b1; tick(); reset = 1'b0;
      aLevel = 3'd2; aWe = 1'b1; aWa = 5'd7; aWd = 32'h55; tick();
      aWa = 5'd2; aWd = 32'h99; tick();
      aWe = 1'b0; aLe = 1'b1; aRa = {5'd2, 5'd7};
      @(negedge clk);
      chk("scrub_strobe_busy", 32'(aBusy), 32'h0);
      tick();
      aLe = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (aBusy) begin
            cnt++;
            if (rdA(0) !== 32'h0 || rdA(1) !== 32'h99) begin
               chk($sformatf("scrub_x7_c%0d", i), rdA(0), 32'h0);
               chk($sformatf("scrub_x2_c%0d", i), rdA(1), 32'h99);
            end
         end
         tick();
      end
      chk("scrub_busy_cycles", 32'(cnt), 32'd31);
      @(negedge clk);
      chk("scrub_after_x7", rdA(0), 32'h0);
      chk("scrub_after_x2", rdA(1), 32'h99);
      tick();

      // Write and second levelEnter during scrub are ignored
      reset = 1'b1; tick(); reset = 1'b0;
      aLevel = 3'd6; aWe = 1'b1; aWa = 5'd3; aWd = 32'h33; tick();
      aWa = 5'd2; aWd = 32'h44; tick();
      aWe = 1'b0; aLevel = 3'd4; aLe = 1'b1; tick();
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         aLevel = 3'd4; aWe = 1'b0; aLe = 1'b0; aRa = {5'd2, 5'd9};
         if (i == 3) begin aLevel = 3'd5; aWe = 1'b1; aWa = 5'd9; aWd = 32'h1; end
         if (i == 5) aLe = 1'b1;
         @(negedge clk);
         if (aBusy) cnt++;
         if (i == 3) chk("scrub_no_bypass_x9", rdA(0), 32'h0);
         tick();
      end
      aWe = 1'b0; aLe = 1'b0;
      chk("scrub_ignore_busy_cycles", 32'(cnt), 32'd31);
      aLevel = 3'd5; aRa = {5'd2, 5'd9};
      @(negedge clk);
      chk("scrub_ignored_write_x9", rdA(0), 32'h0);
      chk("scrub_shared_x2", rdA(1), 32'h44);
      tick();
      aLevel = 3'd6; aRa = {5'd2, 5'd3};
      @(negedge clk);
      chk("scrub_other_level_x3", rdA(0), 32'h33);
      tick();

      // Reset at busy cycle 10 of a scrub of level 6
      aLe = 1'b1; tick(); aLe = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40 && cnt < 10; i++) begin
         @(negedge clk);
         if (aBusy) cnt++;
         if (cnt == 10) reset = 1'b1;
         tick();
      end
      reset = 1'b0;
      chk("rst_scrub_reached10", 32'(cnt), 32'd10);
      @(negedge clk);
      chk("rst_scrub_busy", 32'(aBusy), 32'h0);
      chk("rst_scrub_x3", rdA(0), 32'h0);
      chk("rst_scrub_x2", rdA(1), 32'h0);
      tick();
`else
      // Without the scrub engine levelEnter is ignored and banks retain contents
      reset = 1'b1; tick(); reset = 1'b0;
      aLevel = 3'd2; aWe = 1'b1; aWa = 5'd7; aWd = 32'h55; tick();
      aWe = 1'b0; aLe = 1'b1; tick(); aLe = 1'b0;
      aRa = {5'd0, 5'd7};
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (aBusy) cnt++;
         tick();
      end
      chk("noscrub_busy", 32'(cnt), 32'h0);
      @(negedge clk);
      chk("noscrub_retain_x7", rdA(0), 32'h55);
      tick();
`endif

      // Four-port, four-level instance: each port returns its own register
      reset = 1'b1; tick(); reset = 1'b0;
      bWe = 1'b1; bLevel = 2'd0; bWa = 5'd1; bWd = 32'h0BAD; tick();
      bLevel = 2'd3;
      for (int r = 1; r <= 4; r++) begin
         bWa = 5'(r); bWd = 32'h1000 + 32'(r); tick();
      end
      bWe = 1'b0;
      bRa = {5'd4, 5'd3, 5'd2, 5'd1};
      @(negedge clk);
      for (int p = 0; p < 4; p++) chk($sformatf("b4_fwd_p%0d", p), rdB(p), 32'h1001 + 32'(p));
      tick();
      bRa = {5'd1, 5'd2, 5'd3, 5'd4};
      @(negedge clk);
      for (int p = 0; p < 4; p++) chk($sformatf("b4_rev_p%0d", p), rdB(p), 32'h1004 - 32'(p));
      tick();
      bLevel = 2'd0;
      @(negedge clk);
      chk("b4_level0_x1", rdB(3), 32'h0BAD);
      chk("b4_busy", 32'(bBusy), 32'h0);
      tick();

      // Randomized traffic against the behavioural model
      reset = 1'b1;
      @(posedge clk);
      modelEdge(1'b1, 0, 1'b0, 0, 32'h0, 1'b0);
      #1;
      for (int c = 0; c < 600; c++) begin
         reset  = ($urandom_range(0, 199) == 0);
         aLevel = 3'($urandom);
         aWe    = 1'($urandom);
         aWa    = 5'($urandom);
         aWd    = $urandom;
         aRa    = 10'($urandom);
         aLe    = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 3) == 0) aRa[4:0] = aWa;
         if ($urandom_range(0, 7) == 0) aRa[9:5] = aRa[4:0];
         @(negedge clk);
         for (int p = 0; p < 2; p++)
            chk($sformatf("rand%0d_p%0d", c, p), rdA(p),
                modelRead(int'(aLevel), int'(aRa[p*5 +: 5]), aWe, int'(aWa), aWd));
         chk($sformatf("rand%0d_busy", c), 32'(aBusy), 32'(busyLeft > 0));
         @(posedge clk);
         modelEdge(reset, int'(aLevel), aWe, int'(aWa), aWd, aLe);
         #1;
      end
      reset = 1'b0; aWe = 1'b0; aLe = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
